// File: rtl/parity_tx_serial_if.sv
// parity_tx_serial_if: byte handshake and serial-line signals of the parity transmitter
interface parity_tx_serial_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;
  modport master (output in_data, in_valid, input in_ready, tx, busy, done);
  modport slave  (input in_data, in_valid, output in_ready, tx, busy, done);
endinterface

// File: rtl/parity_tx_serial.sv
// parity_tx_serial: 8-bit serial transmitter framing start, LSB-first data, parity and stop bits
module parity_tx_serial #(
  parameter bit PARITY_ODD = 1'b0
) (
  input logic clk,
  input logic rst_n,
  parity_tx_serial_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [7:0] sh, sh_n;
  logic [2:0] cnt, cnt_n;
  logic par, par_n, tx, tx_n, ready, busy, done;
  // state, latched byte and outputs; outputs are registered from next-state values
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      par   <= 1'b0;
      cnt   <= '0;
      tx    <= 1'b1;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      par   <= par_n;
      cnt   <= cnt_n;
      tx    <= tx_n;
      ready <= state_n == IDLE;
      busy  <= state_n != IDLE;
      done  <= state_n == STOP;
    end
  // frame sequencing; the byte and its parity are captured only at the IDLE handshake
  always_comb begin
    state_n = state;
    sh_n    = sh;
    par_n   = par;
    cnt_n   = cnt;
    case (state)
      IDLE: if (bus.in_valid && ready) begin
        state_n = START;
        sh_n    = bus.in_data;
        par_n   = ^bus.in_data ^ PARITY_ODD;
        cnt_n   = '0;
      end
      START:   state_n = DATA;
      DATA:    if (cnt == 3'd7) state_n = PARITY; else cnt_n = cnt + 3'd1;
      PARITY:  state_n = STOP;
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START  ? 1'b0 :
           state_n == DATA   ? sh_n[cnt_n] :
           state_n == PARITY ? par_n : 1'b1;
  end
  assign bus.tx       = tx;
  assign bus.in_ready = ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
endmodule

// File: tb/tb_parity_tx_serial.sv
// tb_parity_tx_serial: even and odd parity transmitters driven in lockstep against a frame model
module tb_parity_tx_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  int errors = 0;
  int checks = 0;
  parity_tx_serial_if b0 ();
  parity_tx_serial_if b1 ();
  assign b0.in_data = in_data;
  assign b0.in_valid = in_valid;
  assign b1.in_data = in_data;
  assign b1.in_valid = in_valid;
  parity_tx_serial #(.PARITY_ODD(1'b0)) dut_even (.clk(clk), .rst_n(rst_n), .bus(b0));
  parity_tx_serial #(.PARITY_ODD(1'b1)) dut_odd (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;

  // expected line, cycle 0 in bit 0: start 0, data LSB first, parity, stop 1
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input bit odd);
    bit p;
    p = (($countones(d) % 2) == 1) != odd;
    return {1'b1, p, d, 1'b0};
  endfunction

  // one idle cycle, then a single handshake and the 11 frame cycles captured at negedges
  task automatic run_frame(input logic [7:0] d, output logic [10:0] t0, t1, dn0, dn1, bz0, bz1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      t0[i] = b0.tx; t1[i] = b1.tx;
      dn0[i] = b0.done; dn1[i] = b1.done;
      bz0[i] = b0.busy; bz1[i] = b1.busy;
      if (i == 0) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [10:0] t0, t1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b0.tx, b0.in_ready, b0.busy, b0.done, b1.tx, b1.in_ready, b1.busy, b1.done} !== 8'b1100_1100) begin
      errors++;
      $display("FAIL reset_async: got %b want 11001100",
               {b0.tx, b0.in_ready, b0.busy, b0.done, b1.tx, b1.in_ready, b1.busy, b1.done});
    end
    repeat (3) @(negedge clk);
    d = 8'($urandom);
    in_valid = 1'b1;
    in_data = d;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      t0[i] = b0.tx; t1[i] = b1.tx;
      if (i == 0) in_valid = 1'b0;
    end
    checks++;
    if (t0 !== exp_frame(d, 0) || t1 !== exp_frame(d, 1)) begin
      errors++;
      $display("FAIL first_handshake d=%h: got %b/%b want %b/%b", d, t0, t1, exp_frame(d, 0), exp_frame(d, 1));
    end
  endtask

  task automatic test_known();
    logic [10:0] t0, t1, dn0, dn1, bz0, bz1;
    run_frame(8'hA5, t0, t1, dn0, dn1, bz0, bz1);
    checks++;
    if (t0 !== 11'b10101001010) begin
      errors++;
      $display("FAIL a5_even_line: got %b want 10101001010", t0);
    end
    checks++;
    if (dn0 !== 11'h400 || dn1 !== 11'h400) begin
      errors++;
      $display("FAIL a5_done: got %b/%b want 10000000000", dn0, dn1);
    end
    checks++;
    if (bz0 !== 11'h7FF || bz1 !== 11'h7FF) begin
      errors++;
      $display("FAIL a5_busy: got %b/%b want 11111111111", bz0, bz1);
    end
    checks++;
    if (t1[9] !== 1'b1) begin
      errors++;
      $display("FAIL a5_odd_parity: got %b want 1", t1[9]);
    end
    run_frame(8'h01, t0, t1, dn0, dn1, bz0, bz1);
    checks++;
    if (t0[9] !== 1'b1) begin
      errors++;
      $display("FAIL 01_even_parity: got %b want 1", t0[9]);
    end
    run_frame(8'hFF, t0, t1, dn0, dn1, bz0, bz1);
    checks++;
    if (t0[9] !== 1'b0) begin
      errors++;
      $display("FAIL ff_even_parity: got %b want 0", t0[9]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] d;
    logic [10:0] t0, t1;
    logic quiet;
    d = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      t0[i] = b0.tx; t1[i] = b1.tx;
      if (i == 0) in_valid = 1'b0;
      if (i == 3) begin in_valid = 1'b1; in_data = 8'h3C; end
      if (i == 4) begin in_valid = 1'b0; in_data = 8'($urandom); end
    end
    checks++;
    if (t0 !== exp_frame(d, 0) || t1 !== exp_frame(d, 1)) begin
      errors++;
      $display("FAIL ignore_frame d=%h: got %b/%b want %b/%b", d, t0, t1, exp_frame(d, 0), exp_frame(d, 1));
    end
    quiet = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (b0.tx !== 1'b1 || b1.tx !== 1'b1 || b0.busy !== 1'b0 || b1.busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL ignore_no_second_frame: got quiet=%b want 1", quiet);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] t0, t1, dn0, exp0, exp1;
    exp0 = {1'b1, exp_frame(8'hAA, 0), 1'b1, exp_frame(8'h55, 0)};
    exp1 = {1'b1, exp_frame(8'hAA, 1), 1'b1, exp_frame(8'h55, 1)};
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      t0[i] = b0.tx; t1[i] = b1.tx; dn0[i] = b0.done;
      if (i == 0) in_data = 8'hAA;
      if (i == 12) in_valid = 1'b0;
    end
    checks++;
    if (t0 !== exp0 || t1 !== exp1) begin
      errors++;
      $display("FAIL back_to_back_line: got %h/%h want %h/%h", t0, t1, exp0, exp1);
    end
    checks++;
    if (dn0 !== 24'h400400) begin
      errors++;
      $display("FAIL back_to_back_done: got %h want 400400", dn0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic quiet;
    d = 8'($urandom) & 8'hEF;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
    end
    checks++;
    if (b0.tx !== 1'b0 || b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit4: got tx=%b busy=%b want tx=0 busy=1", b0.tx, b0.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b0.tx, b0.in_ready, b0.busy, b0.done, b1.tx, b1.in_ready, b1.busy, b1.done} !== 8'b1100_1100) begin
      errors++;
      $display("FAIL mid_reset_async: got %b want 11001100",
               {b0.tx, b0.in_ready, b0.busy, b0.done, b1.tx, b1.in_ready, b1.busy, b1.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (14) begin
      @(negedge clk);
      if (b0.tx !== 1'b1 || b1.tx !== 1'b1 || b0.busy || b1.busy || b0.done || b1.done) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_stays_idle: got quiet=%b want 1", quiet);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] d, off;
    logic [10:0] t0, t1, dn0, dn1, bz0, bz1;
    off = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) + off;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(d, t0, t1, dn0, dn1, bz0, bz1);
      checks++;
      if (t0 !== exp_frame(d, 0) || t1 !== exp_frame(d, 1)) begin
        errors++;
        $display("FAIL sweep_line d=%h: got %b/%b want %b/%b", d, t0, t1, exp_frame(d, 0), exp_frame(d, 1));
      end
      checks++;
      if (($countones(t0[9:1]) % 2) != 0 || ($countones(t1[9:1]) % 2) != 1) begin
        errors++;
        $display("FAIL sweep_ones d=%h: got %0d/%0d ones want even/odd", d, $countones(t0[9:1]), $countones(t1[9:1]));
      end
      checks++;
      if (dn0 !== 11'h400 || dn1 !== 11'h400 || bz0 !== 11'h7FF || bz1 !== 11'h7FF) begin
        errors++;
        $display("FAIL sweep_done_busy d=%h: got %b/%b %b/%b want done 10000000000 busy 11111111111",
                 d, dn0, dn1, bz0, bz1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
